div_unit: RTL and testbench

- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Runs a radix-2 restoring algorithm: one trial subtraction per cycle, XLEN iterations.
- Sits beside the single-cycle ALU adder/subtractor in the execute stage. Valid/ready handshake on both the issue side and the result side.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 176 +++++++++++++++++
 tb/tb_div_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op/state encodings and widths for the radix-2 divider
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_XLEN);

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_trial;

  // The partial remainder is always below the divisor, so the shifted value
  // fits XLEN+1 bits and the trial's top bit is a reliable borrow flag.
  assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_divisor};
  assign o_rem    = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
  assign o_quo    = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit (option: DIV_EARLY_OUT_EN)
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      r_state;
  div_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_result;
  logic            r_sel_rem;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_div0;
  logic            r_ovf;

  logic            w_accept;
  logic            w_is_signed;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_dividend_abs;
  logic [XLEN-1:0] w_divisor_abs;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_result_fix;

  assign w_accept    = start_valid && (r_state == IDLE);
  assign w_is_signed = ~op[0];
  assign w_div0      = (divisor == '0);
  assign w_ovf       = w_is_signed && (dividend == MIN_NEG) && (divisor == '1);

  // Magnitudes; -0x8000_0000 wraps back to itself, which is 2^31 read unsigned.
  assign w_dividend_abs = (w_is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign w_divisor_abs  = (w_is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  assign result = r_result;

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    start_ready  = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
`ifdef DIV_EARLY_OUT_EN
          w_state_next = (w_div0 || w_ovf) ? FIXUP : CALC;
`else
          w_state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_state_next = FIXUP;
        end
      end
      FIXUP: begin
        w_state_next = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Sign correction, then the RISC-V special-case values take precedence.
  always_comb begin
    w_quo_fix = r_q_neg ? -r_quo : r_quo;
    w_rem_fix = r_r_neg ? -r_rem : r_rem;
    if (r_div0) begin
      w_quo_fix = '1;
      w_rem_fix = r_dividend;
    end else if (r_ovf) begin
      w_quo_fix = MIN_NEG;
      w_rem_fix = '0;
    end
    w_result_fix = r_sel_rem ? w_rem_fix : w_quo_fix;
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_result   <= '0;
      r_sel_rem  <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt      <= CNT_LAST;
            r_rem      <= '0;
            r_quo      <= w_dividend_abs;
            r_divisor  <= w_divisor_abs;
            r_dividend <= dividend;
            r_sel_rem  <= op[1];
            r_q_neg    <= w_is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_r_neg    <= w_is_signed && dividend[XLEN-1];
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIXUP: begin
          r_result <= w_result_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit (honours DIV_EARLY_OUT_EN)
module tb_div_unit;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .dividend     (dividend),
    .divisor      (divisor),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f_op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f_op[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && special) ? 2 : 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, scramble inputs and poke the handshakes while busy,
  // then compare against the scoreboard and retire the result.
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    int          lat;
    bit          stayed_low;
    logic [31:0] held;
    exp_q.push_back(model(t_op, a, b));
    lat_q.push_back(model_lat(t_op, a, b));
    check({tag, " start_ready idle"}, {31'd0, start_ready}, 32'd1);
    op          = t_op;
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    tick();
    lat        = 1;
    stayed_low = 1'b1;
    op         = 2'($urandom_range(0, 3));
    dividend   = $urandom;
    divisor    = $urandom;
    while (!result_valid && lat < 100) begin
      if (start_ready || !busy) stayed_low = 1'b0;
      start_valid  = 1'($urandom_range(0, 1));
      result_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    start_valid  = 1'b0;
    result_ready = 1'b0;
    if (start_ready) stayed_low = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(lat_q.pop_front()));
    check({tag, " busy window"}, {31'd0, stayed_low}, 32'd1);
    held = result;
    check({tag, " result"}, held, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, {31'd0, result_valid}, 32'd1);
      check({tag, " hold result"}, result, held);
      check({tag, " hold start_ready"}, {31'd0, start_ready}, 32'd0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, " valid drop"}, {31'd0, result_valid}, 32'd0);
    check({tag, " back to idle"}, {31'd0, start_ready}, 32'd1);
    check({tag, " result kept"}, result, held);
  endtask

  initial begin
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    op           = 2'b00;
    dividend     = 32'd0;
    divisor      = 32'd0;
    tick();
    tick();
    check("reset start_ready", {31'd0, start_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result_valid", {31'd0, result_valid}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    tick();

    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 0, "divu 100/7");
    run_op(DIV_OP_REMU, 32'd100, 32'd7, 0, "remu 100/7");
    run_op(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, "div -100/7");
    run_op(DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 0, "rem -100/7");
    run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
    run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem ovf");
    run_op(DIV_OP_DIVU, 32'd5, 32'd0, 0, "divu 5/0");
    run_op(DIV_OP_REMU, 32'd5, 32'd0, 0, "remu 5/0");
    run_op(DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 0, "div -5/0");
    run_op(DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 0, "rem -5/0");
    run_op(DIV_OP_DIVU, 32'd1000, 32'd10, 10, "backpressure");

    op          = DIV_OP_DIVU;
    dividend    = 32'd12345;
    divisor     = 32'd7;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (14) tick();
    check("mid-calc busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort result_valid", {31'd0, result_valid}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort start_ready", {31'd0, start_ready}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    run_op(DIV_OP_DIVU, 32'd9, 32'd3, 0, "divu 9/3 after reset");

    for (int n = 0; n < 300; n++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, "random");
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
